// File: rtl/seq_mac_alu.sv
// Handshaked execute-stage ALU with accumulator and iterative shift-add MUL/MAC.
// Define MAC_SATURATE_EN to make the MAC accumulate saturate on signed overflow.
module seq_mac_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             OverFlow,
    output logic             Zero,
    output logic             Negative,
    output logic [WIDTH-1:0] Accumulator,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_MAC = 4'd4, OP_MUL = 4'd5, OP_CLR = 4'd6, OP_LD  = 4'd7;

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
    state_t state, state_nxt;

    logic             is_mac;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand, mplier, prod, acc;
    logic             mul_op, last;

    assign mul_op      = (ALUControl == OP_MUL) || (ALUControl == OP_MAC);
    assign last        = (cnt == CW'(WIDTH - 1));
    assign Accumulator = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = mul_op ? MULT : DONE;
            end
            MULT: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle ops evaluated straight from the operands on accept.
    logic [WIDTH:0]   sum_add, sum_sub;
    logic [WIDTH-1:0] s_res;
    logic             s_c, s_v;

    always_comb begin
        sum_add = {1'b0, A} + {1'b0, B};
        sum_sub = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        s_res   = '0;
        s_c     = 1'b0;
        s_v     = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                s_res = sum_add[WIDTH-1:0];
                s_c   = sum_add[WIDTH];
                s_v   = (A[WIDTH-1] == B[WIDTH-1]) && (s_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                s_res = sum_sub[WIDTH-1:0];
                s_c   = sum_sub[WIDTH];
                s_v   = (A[WIDTH-1] != B[WIDTH-1]) && (s_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  s_res = A & B;
            OP_OR:   s_res = A | B;
            OP_LD:   s_res = A;
            default: s_res = '0;
        endcase
    end

    // Final iteration folds its partial product in combinationally so MAC can
    // retire on the same edge that leaves MULT.
    logic [WIDTH-1:0] prod_nxt, mac_sum, mac_res, fin_res;
    logic             mac_v;

    always_comb begin
        prod_nxt = prod + (mplier[0] ? mcand : '0);
        mac_sum  = acc + prod_nxt;
        mac_v    = (acc[WIDTH-1] == prod_nxt[WIDTH-1]) && (mac_sum[WIDTH-1] != acc[WIDTH-1]);
        mac_res  = mac_sum;
`ifdef MAC_SATURATE_EN
        if (mac_v) mac_res = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        fin_res  = is_mac ? mac_res : prod_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_mac   <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            acc      <= '0;
            Result   <= '0;
            Carry    <= 1'b0;
            OverFlow <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    is_mac <= (ALUControl == OP_MAC);
                    cnt    <= '0;
                    mcand  <= A;
                    mplier <= B;
                    prod   <= '0;
                    if (!mul_op) begin
                        Result   <= s_res;
                        Carry    <= s_c;
                        OverFlow <= s_v;
                        Zero     <= (s_res == '0);
                        Negative <= s_res[WIDTH-1];
                        if (ALUControl == OP_CLR) acc <= '0;
                        if (ALUControl == OP_LD)  acc <= A;
                    end
                end
                MULT: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        if (is_mac) acc <= mac_res;
                        Result   <= fin_res;
                        Carry    <= 1'b0;
                        OverFlow <= is_mac && mac_v;
                        Zero     <= (fin_res == '0);
                        Negative <= fin_res[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mac_alu.sv
// Scoreboard bench for seq_mac_alu: driver pushes modelled results, monitor pops on handshake.
module tb_seq_mac_alu;
    localparam int W = 32;
    localparam longint MAXS = (longint'(1) << (W-1)) - 1;
    localparam longint MINS = -(longint'(1) << (W-1));

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic Carry, OverFlow, Zero, Negative;
    logic [3:0]   ALUControl;
    logic [W-1:0] A, B, Result, Accumulator;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c, v, z, n;
        logic [W-1:0] acc;
        logic [7:0]   lat, bsy;
    } exp_t;

    exp_t q[$];
    int nvec = 0, nerr = 0, cyc = 0, acc_cyc = 0, busy_cnt = 0;
    logic prev_ov = 1'b0, idle_chk = 1'b0;
    logic [W-1:0] acc_m;

    always #5 clk = ~clk;

    seq_mac_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Carry(Carry), .OverFlow(OverFlow), .Zero(Zero), .Negative(Negative),
        .Accumulator(Accumulator), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb, sr;
        logic [2*W-1:0] p;
        logic [W-1:0] pl;
        e  = '0;
        sa = $signed(a);
        sb = $signed(b);
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        pl = p[W-1:0];
        case (op)
            4'd0: begin e.res = a + b; e.c = (e.res < a); sr = sa + sb; e.v = (sr > MAXS) || (sr < MINS); end
            4'd1: begin e.res = a - b; e.c = (a >= b);    sr = sa - sb; e.v = (sr > MAXS) || (sr < MINS); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: begin
                sr  = longint'($signed(acc_m)) + longint'($signed(pl));
                e.v = (sr > MAXS) || (sr < MINS);
                e.res = acc_m + pl;
`ifdef MAC_SATURATE_EN
                if (e.v) e.res = (sr > 0) ? W'(MAXS) : W'(MINS);
`endif
                acc_m = e.res;
            end
            4'd5: e.res = pl;
            4'd6: begin e.res = '0; acc_m = '0; end
            4'd7: begin e.res = a;  acc_m = a;  end
            default: e.res = '0;
        endcase
        e.z   = (e.res == '0);
        e.n   = e.res[W-1];
        e.acc = acc_m;
        e.lat = (op == 4'd4 || op == 4'd5) ? 8'(W + 1) : 8'd1;
        e.bsy = (op == 4'd4 || op == 4'd5) ? 8'(W) : 8'd0;
        q.push_back(e);
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin chk("in_ready_timeout", in_ready, 1); return; end
        #1;
        in_valid = 1'b1; ALUControl = op; A = a; B = b;
        push(op, a, b);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        in_valid = 1'b0; ALUControl = 4'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("drain", q.size(), 0);
    endtask

    // Monitor: latency on rise, stability while held, full compare on handshake.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_ov  <= 1'b0;
            busy_cnt <= 0;
            idle_chk <= 1'b0;
        end else begin
            prev_ov  <= out_valid;
            busy_cnt <= busy_cnt + int'(busy);
            if (idle_chk) begin
                chk("idle_after_hs", {in_ready, out_valid}, 2'b10);
                idle_chk <= 1'b0;
            end
            if (out_valid && q.size() == 0) chk("stale_result", out_valid, 0);
            else if (out_valid) begin
                if (!prev_ov) chk("latency", cyc + 1 - acc_cyc, q[0].lat);
                if (!out_ready) begin
                    chk("hold_result", Result, q[0].res);
                    chk("hold_in_ready", in_ready, 0);
                end else begin
                    chk("result", Result, q[0].res);
                    chk("flags_cvzn", {Carry, OverFlow, Zero, Negative}, {q[0].c, q[0].v, q[0].z, q[0].n});
                    chk("accumulator", Accumulator, q[0].acc);
                    chk("busy_cycles", busy_cnt, q[0].bsy);
                    void'(q.pop_front());
                    busy_cnt <= 0;
                    idle_chk <= 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ALUControl = '0; A = '0; B = '0; acc_m = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", Result, 0);
        chk("rst_acc", Accumulator, 0);
        chk("rst_flags", {Carry, OverFlow, Zero, Negative}, 0);
        #1 rst_n = 1'b1;

        send(4'd0, 15, 10);
        send(4'd1, 20, 15);
        send(4'd1, 0, 1);
        send(4'd1, 7, 7);
        send(4'd0, 32'h7FFF_FFFF, 1);
        send(4'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        send(4'd7, 7, 0);
        send(4'd4, 5, 3);
        send(4'd7, 32'h7FFF_FFF0, 0);
        send(4'd4, 1, 32'h20);
        send(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(4'd3, 32'hF0F0_0000, 32'h0000_0F0F);
        send(4'd6, 0, 0);
        send(4'd9, 1, 2);
        drain();

        // Consumer stalls for 5 cycles on an all-zero AND result.
        out_ready = 1'b0;
        send(4'd2, 32'hAAAA_AAAA, 32'h5555_5555);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("hold_wait_valid", out_valid, 1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        for (int i = 0; i < 12; i++) send(4'($urandom_range(0, 9)), $urandom, $urandom);
        drain();

        // Reset mid-MAC discards the op and clears the accumulator.
        send(4'd7, 3, 0);
        send(4'd4, 32'h1234, 32'h77);
        n = 0;
        while (busy_cnt < 10 && n < 100) begin @(negedge clk); n++; end
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_acc", Accumulator, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_result", Result, 0);
        q.delete();
        acc_m = '0;
        #1 rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("midrst_no_stale", out_valid, 0);
        send(4'd0, 1, 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/seq_mac_alu.md
# seq_mac_alu

Parametrised, handshaked ALU with an internal accumulator and an iterative shift-add multiplier, replacing the purely combinational ALU in the execute stage of the 32-bit RISC-V core.
- Single-cycle ops: ADD, SUB, AND, OR, accumulator load and clear.
- Multi-cycle ops: MUL and MAC.
- Outputs the same Carry/OverFlow/Zero/Negative flags as the existing ALU.
- Results are held until the consumer accepts them.

## Interface
- WIDTH, 32: operand, result and accumulator width; must be ≥ 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset. Samples on clk; low clears all state.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request. High only in IDLE.
- ALUControl  input  4  opcode, sampled on accept.
- A, B  input  WIDTH  operands, sampled on accept.
- out_valid  output  1  Result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- Result  output  WIDTH  operation result.
- Carry, OverFlow, Zero, Negative  output  1 each  status flags, registered with Result.
- Accumulator  output  WIDTH  current accumulator register.
- busy  output  1  high in MULT state.

## Operation
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 SUB: A−B.
  - 0010 AND.
  - 0011 OR.
  - 0100 MAC: acc ← acc + low WIDTH bits of A·B; Result = new acc.
  - 0101 MUL: Result = low WIDTH bits of A·B; acc unchanged.
  - 0110 ACC_CLR: acc ← 0; Result = 0.
  - 0111 ACC_LD: acc ← A; Result = A.
  - 1000–1111: Result = 0, Zero = 1, other flags 0.
- States:
  - IDLE: in_ready = 1. On in_valid, latch the op and operands.
    - Single-cycle op → DONE.
    - MUL/MAC → MULT, with count = 0, product = 0, multiplicand = A, multiplier = B.
  - MULT: each cycle, if multiplier[0] = 1, product += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++. After the WIDTH-th iteration → DONE, and MAC updates acc in that same transition.
  - DONE: out_valid = 1. Result and flags are stable. On out_ready → IDLE.
- Arithmetic and flags:
  - ADD: Carry = carry out of bit WIDTH−1.
  - SUB: computed as A + ~B + 1; Carry = 1 when no borrow (A ≥ B unsigned).
  - OverFlow: signed overflow of ADD/SUB, or of the MAC accumulate addition.
  - MUL/AND/OR/ACC_*: Carry = 0, OverFlow = 0.
  - Zero = (Result == 0).
  - Negative = Result[WIDTH−1].
- Product: only the low WIDTH bits are kept, which is sign-agnostic. The multiplier needs no extra bits.
- Reset: rst_n low on any edge, including mid-MULT → IDLE, acc = 0, Result = 0, all flags 0, out_valid = 0, busy = 0, in_ready = 1 after the edge. An in-flight op is discarded.

## Timing
- Accept cycle N, single-cycle op: out_valid high from cycle N+1.
- Accept cycle N, MUL/MAC: busy in cycles N+1..N+WIDTH; out_valid from cycle N+WIDTH+1. This is 33 cycles for WIDTH = 32.
- out_valid stays high, and Result/flags stay constant, until out_ready is sampled high.
- If out_ready is already high when out_valid rises, the handshake completes in that cycle. in_ready rises the following cycle.
- No overlap: at most one op is in flight. Minimum issue interval is 2 cycles for single-cycle ops.
- A, B and ALUControl may change freely after accept.
- Accumulator output updates in the same cycle out_valid rises (MAC, ACC_CLR, ACC_LD).

## Configuration
- MAC_SATURATE_EN, when defined:
  - MAC accumulate saturates on signed overflow: positive → 2^(WIDTH−1)−1, negative → −2^(WIDTH−1).
  - OverFlow = 1 in that case.
  - Saturation applies to MAC only; ADD/SUB still wrap.
- Without it: MAC wraps modulo 2^WIDTH; OverFlow still reports signed overflow.

## Test plan
- ADD A = 15, B = 10, out_ready = 1 → Result = 25, all flags 0, out_valid exactly 1 cycle after accept.
- SUB 20−15 → Result = 5, Carry = 1. SUB 0−1 → Result = 0xFFFFFFFF, Negative = 1, Carry = 0. SUB 7−7 → Zero = 1.
- ACC_LD A = 7, then MAC A = 5, B = 3 → busy for 32 cycles, out_valid 33 cycles after accept, Result = Accumulator = 22.
- ACC_LD 0x7FFFFFF0, then MAC A = 1, B = 0x20:
  - With MAC_SATURATE_EN → Result = 0x7FFFFFFF, OverFlow = 1.
  - Without → Result = 0x80000010, OverFlow = 1, Negative = 1.
- AND 0xAAAAAAAA & 0x55555555 with out_ready held low 5 cycles → Result = 0, Zero = 1 held stable; in_ready = 0 throughout; IDLE one cycle after out_ready rises.
- Start MAC, pull rst_n low at busy cycle 10 → next edge: busy = 0, out_valid = 0, Accumulator = 0, in_ready = 1; no stale result appears afterwards.
